// File: rtl/gpreg_bank_pkg.sv
// core_pkg: shared definitions for the general-purpose register bank.
//   XLEN_DEF      default register width
//   NREG_E/NREG_I the only legal register counts (RV32E / RV32I)
//   dump_state_e  state encoding of the register-dump engine
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_E   = 16;
  localparam int NREG_I   = 32;

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_RUN  = 1'b1
  } dump_state_e;

endpackage

// File: rtl/gpreg_bank_if.sv
// gpreg_bank_if: write port, packed read ports and the dump stream of the
// register bank.
//   master: drives we/waddr/wdata/raddr/dump_start/dump_ready (core, bench)
//   slave : drives rdata and the dump_* / busy outputs (gpreg_bank)
interface gpreg_bank_if
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_E,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                dump_start;
  logic                dump_valid;
  logic                dump_ready;
  logic [AW-1:0]       dump_idx;
  logic [XLEN-1:0]     dump_data;
  logic                dump_last;
  logic                busy;

  modport master (
    output we, waddr, wdata, raddr, dump_start, dump_ready,
    input  rdata, dump_valid, dump_idx, dump_data, dump_last, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr, dump_start, dump_ready,
    output rdata, dump_valid, dump_idx, dump_data, dump_last, busy
  );

endinterface

// File: rtl/gpreg_bank_dump.sv
// gpreg_dump: register-dump sequencer. Walks dump_idx from 1 to NREG-1,
// advancing on each valid/ready handshake.
//   clk, rst          clock, asynchronous active-low reset
//   dump_start        one-cycle start request (ignored while running)
//   dump_ready        sink accepts the current beat
//   dump_valid        beat presented (equals busy)
//   dump_idx          index of the presented register
//   dump_last         presented beat is x(NREG-1)
//   busy              dump in progress
//
// state     | meaning
// DUMP_IDLE | no dump; waits for dump_start, dump_idx held at 0
// DUMP_RUN  | beat dump_idx presented until accepted
module gpreg_dump
  import core_pkg::*;
#(
  parameter int NREG = NREG_E,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dump_start,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic [AW-1:0] dump_idx,
  output logic          dump_last,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  dump_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      DUMP_IDLE: begin
        if (dump_start) begin
          state_d = DUMP_RUN;
          idx_d   = FIRST_IDX;
        end
      end
      DUMP_RUN: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DUMP_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + FIRST_IDX;
          end
        end
      end
      default: begin
        state_d = DUMP_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy       = (state_q == DUMP_RUN);
  assign dump_valid = busy;
  assign dump_idx   = idx_q;
  assign dump_last  = busy && (idx_q == LAST_IDX);

endmodule

// File: rtl/gpreg_bank.sv
// gpreg_bank: parametrised RISC-V integer register file with NRD
// combinational read ports, one write port and a built-in register-dump
// engine streaming x1..x(NREG-1) over valid/ready.
//   clk   single rising-edge clock
//   rst   asynchronous active-low reset
//   bus   gpreg_bank_if.slave: we/waddr/wdata, raddr/rdata (packed per
//         port), dump_start/dump_ready in, dump_valid/idx/data/last, busy out
// Optional build macro GPREG_BYPASS_EN: a same-cycle write is forwarded to
// matching rdata ports (never to the dump port).
module gpreg_bank
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_E,
  parameter int NRD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  gpreg_bank_if.slave       bus
);

  localparam int AW = $clog2(NREG);

  if (!(NREG == NREG_E || NREG == NREG_I)) begin : g_bad_nreg
    $error("gpreg_bank: NREG must be 16 or 32");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("gpreg_bank: NRD must be 1..4");
  end

  // Entry 0 is never written; the read muxes force it to zero anyway.
  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (bus.we && (bus.waddr != '0)) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  logic [NRD*XLEN-1:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    for (int k = 0; k < NRD; k++) begin
      if (bus.raddr[k*AW +: AW] != '0) begin
        rdata_c[k*XLEN +: XLEN] = regs[bus.raddr[k*AW +: AW]];
`ifdef GPREG_BYPASS_EN
        if (bus.we && (bus.waddr == bus.raddr[k*AW +: AW]))
          rdata_c[k*XLEN +: XLEN] = bus.wdata;
`endif
      end
    end
  end

  assign bus.rdata = rdata_c;

  logic [AW-1:0] dump_idx;

  gpreg_dump #(
    .NREG (NREG),
    .AW   (AW)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .dump_start (bus.dump_start),
    .dump_ready (bus.dump_ready),
    .dump_valid (bus.dump_valid),
    .dump_idx   (dump_idx),
    .dump_last  (bus.dump_last),
    .busy       (bus.busy)
  );

  // Live read with no bypass: the sink captures the value held before any
  // write landing on the same edge as its handshake.
  assign bus.dump_idx  = dump_idx;
  assign bus.dump_data = (dump_idx == '0) ? '0 : regs[dump_idx];

endmodule

// File: tb/tb_gpreg_bank.sv
module tb_gpreg_bank;

  logic clk;
  logic rst_a, rst_b;
  int   checks, failures;

  logic [31:0] mod_a [16];
  logic [31:0] mod_b [32];

  int beats, cyc, exp_idx, prev_idx;
  bit prev_stall, hit;

  gpreg_bank_if #(.XLEN(32), .NREG(16), .NRD(2)) a ();
  gpreg_bank_if #(.XLEN(32), .NREG(32), .NRD(2)) b ();

  gpreg_bank #(.XLEN(32), .NREG(16), .NRD(2)) dut_a (.clk(clk), .rst(rst_a), .bus(a));
  gpreg_bank #(.XLEN(32), .NREG(32), .NRD(2)) dut_b (.clk(clk), .rst(rst_b), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the models follow the architectural write rule.
  task automatic tick();
    @(posedge clk);
    if (rst_a && a.we && a.waddr != 4'd0) mod_a[a.waddr] = a.wdata;
    if (rst_b && b.we && b.waddr != 5'd0) mod_b[b.waddr] = b.wdata;
    #1;
  endtask

  function automatic logic [31:0] rd_a(input int k);
    return a.rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_b(input int k);
    return b.rdata[k*32 +: 32];
  endfunction

  function automatic logic [31:0] exp_a(input int addr);
    if (addr == 0) return 32'h0;
`ifdef GPREG_BYPASS_EN
    if (a.we && int'(a.waddr) == addr) return a.wdata;
`endif
    return mod_a[addr];
  endfunction

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 16; i++) mod_a[i] = 32'h0;
    for (int i = 0; i < 32; i++) mod_b[i] = 32'h0;
    rst_a = 1'b0; rst_b = 1'b0;
    a.we = 1'b0; a.waddr = '0; a.wdata = '0; a.raddr = '0;
    a.dump_start = 1'b0; a.dump_ready = 1'b0;
    b.we = 1'b0; b.waddr = '0; b.wdata = '0; b.raddr = '0;
    b.dump_start = 1'b0; b.dump_ready = 1'b0;
    #12;
    rst_a = 1'b1; rst_b = 1'b1;

    // Reset state
    a.raddr = {4'd0, 4'd5};
    #1;
    chk("rst_rdata0", rd_a(0), 32'h0);
    chk("rst_rdata1", rd_a(1), 32'h0);
    chk("rst_valid", 32'(a.dump_valid), 32'h0);
    chk("rst_busy", 32'(a.busy), 32'h0);
    chk("rst_last", 32'(a.dump_last), 32'h0);
    chk("rst_ddata", a.dump_data, 32'h0);

    // Basic write, x0 write discarded
    a.we = 1'b1; a.waddr = 4'd3; a.wdata = 32'hDEADBEEF;
    tick();
    a.waddr = 4'd0; a.wdata = 32'h00001234;
    tick();
    a.we = 1'b0;
    a.raddr = {4'd0, 4'd3};
    #1;
    chk("wr_x3", rd_a(0), 32'hDEADBEEF);
    chk("wr_x0", rd_a(1), 32'h0);

    // Same-cycle write/read on x7
    a.raddr = {4'd7, 4'd3};
    a.we = 1'b1; a.waddr = 4'd7; a.wdata = 32'hA5A5A5A5;
    #1;
`ifdef GPREG_BYPASS_EN
    chk("same_cycle_x7", rd_a(1), 32'hA5A5A5A5);
`else
    chk("same_cycle_x7", rd_a(1), 32'h0);
`endif
    tick();
    a.we = 1'b0;
    #1;
    chk("next_cycle_x7", rd_a(1), 32'hA5A5A5A5);

    // Random writes and reads against the model
    for (int n = 0; n < 40; n++) begin
      a.we    = 1'($urandom_range(0, 1));
      a.waddr = 4'($urandom_range(0, 15));
      a.wdata = $urandom;
      a.raddr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      if (n % 8 == 0) a.raddr = {a.waddr, a.waddr};
      #1;
      chk("rand_rd0", rd_a(0), exp_a(int'(a.raddr[3:0])));
      chk("rand_rd1", rd_a(1), exp_a(int'(a.raddr[7:4])));
      tick();
    end

    // Preload x(i) = i*0x11
    a.we = 1'b1;
    for (int i = 1; i < 16; i++) begin
      a.waddr = 4'(i); a.wdata = 32'(i) * 32'h11;
      tick();
    end
    a.we = 1'b0;

    // Full dump, ready held high
    a.dump_ready = 1'b1;
    a.dump_start = 1'b1;
    tick();
    a.dump_start = 1'b0;
    chk("d1_first_valid", 32'(a.dump_valid), 32'h1);
    chk("d1_first_idx", 32'(a.dump_idx), 32'h1);
    beats = 0; cyc = 0; exp_idx = 1;
    while (beats < 15 && cyc < 40) begin
      if (a.dump_valid && a.dump_ready) begin
        chk("d1_idx", 32'(a.dump_idx), 32'(exp_idx));
        chk("d1_data", a.dump_data, 32'(exp_idx) * 32'h11);
        chk("d1_last", 32'(a.dump_last), 32'(exp_idx == 15));
        exp_idx++; beats++;
      end
      tick(); cyc++;
    end
    chk("d1_beats", 32'(beats), 32'd15);
    chk("d1_cycles", 32'(cyc), 32'd15);
    chk("d1_busy_fall", 32'(a.busy), 32'h0);

    // Start in the cycle busy falls begins a new dump
    a.dump_start = 1'b1;
    tick();
    a.dump_start = 1'b0;
    chk("d2_restart_valid", 32'(a.dump_valid), 32'h1);
    chk("d2_restart_idx", 32'(a.dump_idx), 32'h1);

    // Throttled dump with concurrent writes and an extra start
    beats = 0; cyc = 0; exp_idx = 1; prev_stall = 1'b0; prev_idx = 0;
    while (beats < 15 && cyc < 200) begin
      a.dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      a.dump_start = (cyc == 6);
      a.we    = 1'($urandom_range(0, 1));
      a.waddr = 4'($urandom_range(0, 15));
      if (cyc % 5 == 0) a.waddr = a.dump_idx;
      a.wdata = $urandom;
      #1;
      if (prev_stall) begin
        chk("d2_hold_valid", 32'(a.dump_valid), 32'h1);
        chk("d2_hold_idx", 32'(a.dump_idx), 32'(prev_idx));
      end
      if (a.dump_valid && a.dump_ready) begin
        chk("d2_idx", 32'(a.dump_idx), 32'(exp_idx));
        chk("d2_data", a.dump_data, mod_a[exp_idx % 16]);
        chk("d2_last", 32'(a.dump_last), 32'(exp_idx == 15));
        exp_idx++; beats++;
      end
      prev_stall = a.dump_valid && !a.dump_ready;
      prev_idx   = int'(a.dump_idx);
      tick(); cyc++;
    end
    a.we = 1'b0; a.dump_start = 1'b0; a.dump_ready = 1'b1;
    chk("d2_beats", 32'(beats), 32'd15);
    #1;
    chk("d2_done_busy", 32'(a.busy), 32'h0);
    tick(); tick();
    chk("d2_no_queued_start", 32'(a.dump_valid), 32'h0);

    // NREG=32: preload, abort by reset at idx 9
    b.we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      b.waddr = 5'(i); b.wdata = $urandom | 32'h1;
      tick();
    end
    b.we = 1'b0;
    b.dump_ready = 1'b1;
    b.dump_start = 1'b1;
    tick();
    b.dump_start = 1'b0;
    cyc = 0; hit = 1'b0;
    while (!hit && cyc < 40) begin
      if (b.dump_valid && int'(b.dump_idx) == 9) hit = 1'b1;
      else begin
        if (b.dump_valid) chk("b_pre_data", b.dump_data, mod_b[b.dump_idx]);
        tick(); cyc++;
      end
    end
    chk("b_reach_idx9", 32'(hit), 32'h1);
    chk("b_cycles_to_9", 32'(cyc), 32'd8);
    b.raddr = {5'd9, 5'd31};
    #2;
    rst_b = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) mod_b[i] = 32'h0;
    chk("b_rst_busy", 32'(b.busy), 32'h0);
    chk("b_rst_valid", 32'(b.dump_valid), 32'h0);
    chk("b_rst_idx", 32'(b.dump_idx), 32'h0);
    chk("b_rst_ddata", b.dump_data, 32'h0);
    chk("b_rst_rd0", rd_b(0), 32'h0);
    chk("b_rst_rd1", rd_b(1), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("b_post_rst_valid", 32'(b.dump_valid), 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      b.raddr = {5'(31 - i), 5'(i)};
      #1;
      chk("b_clear_rd0", rd_b(0), mod_b[i]);
      chk("b_clear_rd1", rd_b(1), mod_b[31 - i]);
    end

    // NREG=32 full dump after reset
    b.dump_start = 1'b1;
    tick();
    b.dump_start = 1'b0;
    chk("b_restart_idx", 32'(b.dump_idx), 32'h1);
    beats = 0; cyc = 0; exp_idx = 1;
    while (beats < 31 && cyc < 80) begin
      if (b.dump_valid && b.dump_ready) begin
        chk("b_idx", 32'(b.dump_idx), 32'(exp_idx));
        chk("b_data", b.dump_data, 32'h0);
        chk("b_last", 32'(b.dump_last), 32'(exp_idx == 31));
        exp_idx++; beats++;
      end
      tick(); cyc++;
    end
    chk("b_beats", 32'(beats), 32'd31);
    chk("b_cycles", 32'(cyc), 32'd31);
    chk("b_busy_fall", 32'(b.busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpreg_bank.md
# gpreg_bank

Parametrised general-purpose register file for the RISC-V core, the successor to the fixed 16-entry `gpreg`. Register count (RV32E/RV32I), data width and read-port count are configurable, and the block adds a built-in register-dump engine. On request, the dump engine streams x1..x(NREG-1) over a valid/ready port, so benches and debug logic no longer reach into the array hierarchically. It sits in the core's decode/writeback path.

## Interface
- `XLEN`, 32: register width in bits.
- `NREG`, 16: number of architectural registers. Legal values are 16 (RV32E) or 32 (RV32I); any other value is an elaboration error.
- `NRD`, 2: number of independent read ports, 1..4.
- `AW`, derived: $clog2(NREG).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `we`  in  1  write enable.
- `waddr`  in  AW  write index.
- `wdata`  in  XLEN  write data.
- `raddr`  in  NRD*AW  packed read indices; port k uses slice k.
- `rdata`  out  NRD*XLEN  packed combinational read data.
- `dump_start`  in  1  one-cycle request to begin a dump.
- `dump_valid`  out  1  a dump beat is presented.
- `dump_ready`  in  1  sink accepts the current beat.
- `dump_idx`  out  AW  register index of the current beat.
- `dump_data`  out  XLEN  value of register `dump_idx`.
- `dump_last`  out  1  current beat is x(NREG-1).
- `busy`  out  1  dump in progress.

## Operation
- x0 reads as zero on every port, including the dump. Writes to index 0 are discarded.
- Writes: when `we`=1 and `waddr`!=0, `wdata` is stored at the rising edge.
- Reads: `rdata[k]` is combinational from `raddr[k]`. Ports are fully independent, and identical addresses are allowed.
- Dump FSM, two states:
  - IDLE: `dump_start`=1 -> RUN, with `dump_idx` loaded to 1.
  - RUN: `dump_valid`=1. When `dump_valid`&`dump_ready`:
    - if `dump_idx`==NREG-1, return to IDLE;
    - otherwise increment `dump_idx`.
- `dump_start` is ignored while in RUN; no restart and no queuing.
- `dump_data` is a live combinational read of r[`dump_idx`]. A core write to the presented register changes `dump_data` after that edge, and the sink samples at the handshake edge. The dump never stalls the core.
- `dump_last` = RUN && `dump_idx`==NREG-1. `busy` = RUN.
- `dump_valid` is never deasserted before its handshake.

## Timing
- Reset (`rst`=0, asynchronous): all registers cleared to 0, FSM to IDLE, `dump_idx`=0. Consequently `dump_valid`, `dump_last`, `busy` and `dump_data` are all 0.
- Write-to-read latency is one edge. A write is visible on `rdata` in the cycle after the write edge (same cycle with bypass; see Configuration).
- Dump timing:
  - `dump_start` at edge N gives `dump_valid`=1 with `dump_idx`=1 in cycle N+1.
  - With `dump_ready` held high, a full dump takes NREG-1 consecutive cycles: 15 for RV32E, 31 for RV32I.
  - After the last handshake, `busy` falls in the next cycle.
  - A `dump_start` arriving in that cycle starts a new dump.
- Reset asserted mid-dump aborts immediately and the FSM returns to IDLE. No partial beat is emitted after reset release.
- A write and a dump handshake on the same register in the same cycle: the sink captures the pre-write value.

## Configuration
- `GPREG_BYPASS_EN`:
  - Defined: a read port k sees `rdata[k]`=`wdata` in the same cycle when `we`=1, `waddr`==`raddr[k]` and `waddr`!=0. The bypass applies only to the `rdata` read ports; the dump port never bypasses.
  - Undefined: `rdata` shows the old register value until after the write edge.

## Structure
- Shared package `core_pkg` holds the XLEN default, the NREG legal values (`NREG_E`=16, `NREG_I`=32) and the dump-state typedef (`DUMP_IDLE`, `DUMP_RUN`).
- One sub-module, `gpreg_dump`, contains the FSM, index counter and handshake outputs. The parent owns the storage array and the read muxes.

## Test plan
- Reset, then read ports 0/1 at x5/x0 -> `rdata`=0/0; `dump_valid`=0, `busy`=0.
- Write x3=0xDEADBEEF, then write x0=0x1234; read x3 and x0 -> 0xDEADBEEF and 0.
- `GPREG_BYPASS_EN` defined: `we`=1, `waddr`=7, `wdata`=0xA5A5A5A5, `raddr[1]`=7 in the same cycle -> `rdata[1]`=0xA5A5A5A5 that cycle. Undefined: old value that cycle, new value the next cycle.
- NREG=16, x(i) preloaded with i*0x11, `dump_start`, `dump_ready`=1 -> 15 beats idx 1..15, data 0x11..0xFF, `dump_last` only on idx 15, `busy` falls the following cycle.
- Dump with `dump_ready` toggled 1-0-0-1… and a second `dump_start` mid-dump -> each index appears exactly once in order; the extra start is ignored.
- NREG=32: `rst` pulsed low at idx 9 mid-dump -> FSM in IDLE, all registers 0; a new `dump_start` restarts at idx 1.
